// File: rtl/seq_tx_if.sv
// seq_tx_if -- handshake/data bundle for the seq_tx serial pattern transmitter.
//
// Parameters:
//   W   pattern width in bits (W >= 2)
//   RW  repeat-count width in bits
//
// Signals:
//   start    request to transmit (master -> slave)
//   pattern  W-bit pattern to transmit (master -> slave)
//   len      frame length minus one, $clog2(W) bits (master -> slave)
//   rep      number of extra frame repeats (master -> slave)
//   x        serial data bit (slave -> master)
//   x_vld    x carries a frame bit this cycle (slave -> master)
//   busy     transmission in progress (slave -> master)
//   done     one-cycle completion pulse (slave -> master)
//
// Modports: master (requester side), slave (the transmitter).
interface seq_tx_if #(
  parameter int W  = 8,
  parameter int RW = 4
);
  localparam int LW = $clog2(W);

  logic          start;
  logic [W-1:0]  pattern;
  logic [LW-1:0] len;
  logic [RW-1:0] rep;
  logic          x;
  logic          x_vld;
  logic          busy;
  logic          done;

  modport master (
    output start, pattern, len, rep,
    input  x, x_vld, busy, done
  );

  modport slave (
    input  start, pattern, len, rep,
    output x, x_vld, busy, done
  );
endinterface

// File: rtl/seq_tx.sv
// seq_tx -- serial pattern transmitter.
//
// Captures a pattern, a frame length and a repeat count on an accepted start,
// then shifts pattern[len:0] out MSB-first on x, rep+1 times back-to-back,
// followed by a one-cycle done pulse. All outputs are registered; the first
// data bit appears one cycle after the edge that accepted start.
//
// Optional feature: define SEQ_TX_PARITY_EN to append one even-parity bit
// (XOR of the frame's transmitted data bits) after every frame.
//
// Ports:
//   clk   single clock, rising edge
//   rst   asynchronous active-low reset
//   bus   seq_tx_if slave modport (start/pattern/len/rep in; x/x_vld/busy/done out)
module seq_tx #(
  parameter int W  = 8,
  parameter int RW = 4
) (
  input  logic    clk,
  input  logic    rst,
  seq_tx_if.slave bus
);

  localparam int LW = $clog2(W);

`ifdef SEQ_TX_PARITY_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    DONE  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd3
  } state_t;
`endif

  state_t        state_reg, state_next;
  logic [W-1:0]  pat_reg,   pat_next;
  logic [LW-1:0] len_reg,   len_next;
  logic [RW-1:0] cnt_reg,   cnt_next;
  logic [LW-1:0] idx_reg,   idx_next;
  logic          x_reg,     x_next;
  logic          vld_reg,   vld_next;
  logic          busy_reg,  busy_next;
  logic          done_reg,  done_next;
  logic          frame_end;

`ifdef SEQ_TX_PARITY_EN
  // Mask selecting the active field pattern[len:0]; bits above len never
  // contribute to the parity since they are never transmitted.
  logic [W-1:0] field_mask;
  logic         parity_bit;

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_mask
      assign field_mask[gi] = (LW'(gi) <= len_reg);
    end
  endgenerate

  assign parity_bit = ^(pat_reg & field_mask);
`endif

  always_comb begin
    state_next = state_reg;
    pat_next   = pat_reg;
    len_next   = len_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    x_next     = 1'b0;
    vld_next   = 1'b0;
    busy_next  = 1'b0;
    done_next  = 1'b0;
    frame_end  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          pat_next   = bus.pattern;
          len_next   = bus.len;
          cnt_next   = bus.rep;
          idx_next   = bus.len;
          // First bit is loaded straight from the inputs so it is on x
          // in the cycle right after the accepting edge.
          x_next     = bus.pattern[bus.len];
          vld_next   = 1'b1;
          busy_next  = 1'b1;
          state_next = SHIFT;
        end
      end

      SHIFT: begin
        // idx_reg names the bit currently on x.
        if (idx_reg != '0) begin
          idx_next  = idx_reg - 1'b1;
          x_next    = pat_reg[idx_reg - 1'b1];
          vld_next  = 1'b1;
          busy_next = 1'b1;
        end else begin
`ifdef SEQ_TX_PARITY_EN
          x_next     = parity_bit;
          vld_next   = 1'b1;
          busy_next  = 1'b1;
          state_next = PAR;
`else
          frame_end  = 1'b1;
`endif
        end
      end

`ifdef SEQ_TX_PARITY_EN
      PAR: begin
        frame_end = 1'b1;
      end
`endif

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Last bit of a frame is on x: either reload for the next repeat with
    // no gap cycle, or finish.
    if (frame_end) begin
      if (cnt_reg != '0) begin
        cnt_next   = cnt_reg - 1'b1;
        idx_next   = len_reg;
        x_next     = pat_reg[len_reg];
        vld_next   = 1'b1;
        busy_next  = 1'b1;
        state_next = SHIFT;
      end else begin
        done_next  = 1'b1;
        state_next = DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      pat_reg   <= '0;
      len_reg   <= '0;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      x_reg     <= 1'b0;
      vld_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      pat_reg   <= pat_next;
      len_reg   <= len_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      x_reg     <= x_next;
      vld_reg   <= vld_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign bus.x     = x_reg;
  assign bus.x_vld = vld_reg;
  assign bus.busy  = busy_reg;
  assign bus.done  = done_reg;

endmodule

// File: tb/tb_seq_tx.sv
// tb_seq_tx -- directed self-checking bench for seq_tx.
// Expected bit sequences are written out per frame; define SEQ_TX_PARITY_EN
// to check the parity-enabled build (frames then include the parity bit).
module tb_seq_tx;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  seq_tx_if #(.W(8), .RW(4)) bus ();

  seq_tx #(.W(8), .RW(4)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction: frame holds the expected bits of one frame (MSB first
  // in frame[flen-1]), repeated rep+1 times. tog wiggles start/inputs while
  // busy; hold leaves start high so the next transaction follows after one
  // IDLE cycle.
  task automatic run_tx(input string name, input logic [7:0] pat, input logic [2:0] len,
                        input logic [3:0] rep, input logic [15:0] frame, input int flen,
                        input bit tog, input bit hold);
    int   n;
    int   f0;
    logic exp_bit;
    n  = flen * (int'(rep) + 1);
    f0 = failures;
    bus.start   = 1'b1;
    bus.pattern = pat;
    bus.len     = len;
    bus.rep     = rep;
    tick();
    bus.start = hold;
    for (int k = 0; k < n; k++) begin
      exp_bit = frame[flen - 1 - (k % flen)];
      check({name, " x"},     {31'd0, bus.x},     {31'd0, exp_bit});
      check({name, " x_vld"}, {31'd0, bus.x_vld}, 32'd1);
      check({name, " busy"},  {31'd0, bus.busy},  32'd1);
      check({name, " done"},  {31'd0, bus.done},  32'd0);
      if (tog) begin
        bus.start   = k[0];
        bus.pattern = 8'($urandom);
        bus.len     = 3'($urandom);
        bus.rep     = 4'($urandom);
      end
      tick();
    end
    if (tog) bus.start = 1'b0;
    check({name, " done_pulse"}, {31'd0, bus.done},  32'd1);
    check({name, " done_vld"},   {31'd0, bus.x_vld}, 32'd0);
    check({name, " done_busy"},  {31'd0, bus.busy},  32'd0);
    check({name, " done_x"},     {31'd0, bus.x},     32'd0);
    tick();
    check({name, " idle_done"},  {31'd0, bus.done},  32'd0);
    check({name, " idle_busy"},  {31'd0, bus.busy},  32'd0);
    check({name, " idle_vld"},   {31'd0, bus.x_vld}, 32'd0);
    $display("tx %s pat=%h len=%0d rep=%0d bits=%0d errors=%0d",
             name, pat, len, rep, n, failures - f0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.pattern = '0;
    bus.len     = '0;
    bus.rep     = '0;
    #3;
    check("rst x",     {31'd0, bus.x},     32'd0);
    check("rst x_vld", {31'd0, bus.x_vld}, 32'd0);
    check("rst busy",  {31'd0, bus.busy},  32'd0);
    check("rst done",  {31'd0, bus.done},  32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    $display("tx reset_release");

`ifdef SEQ_TX_PARITY_EN
    run_tx("p07r1",   8'h07, 3'd2, 4'd1,  16'b1111,      4, 1'b0, 1'b0);
    run_tx("pa5",     8'hA5, 3'd7, 4'd0,  16'b101001010, 9, 1'b0, 1'b0);
    run_tx("p05r2",   8'h05, 3'd2, 4'd2,  16'b1010,      4, 1'b0, 1'b0);
    run_tx("pff_l0",  8'hFF, 3'd0, 4'd0,  16'b11,        2, 1'b0, 1'b0);
    run_tx("ptoggle", 8'hA5, 3'd7, 4'd0,  16'b101001010, 9, 1'b1, 1'b0);
    run_tx("prepmax", 8'h02, 3'd1, 4'd15, 16'b101,       3, 1'b0, 1'b0);
    run_tx("phold1",  8'h03, 3'd1, 4'd0,  16'b110,       3, 1'b0, 1'b1);
    run_tx("phold2",  8'h06, 3'd2, 4'd0,  16'b1100,      4, 1'b0, 1'b0);
`else
    run_tx("a5",      8'hA5, 3'd7, 4'd0,  16'b10100101,  8, 1'b0, 1'b0);
    run_tx("05r2",    8'h05, 3'd2, 4'd2,  16'b101,       3, 1'b0, 1'b0);
    run_tx("ff_l0",   8'hFF, 3'd0, 4'd0,  16'b1,         1, 1'b0, 1'b0);
    run_tx("toggle",  8'hA5, 3'd7, 4'd0,  16'b10100101,  8, 1'b1, 1'b0);
    run_tx("repmax",  8'h02, 3'd1, 4'd15, 16'b10,        2, 1'b0, 1'b0);
    run_tx("hold1",   8'h03, 3'd1, 4'd0,  16'b11,        2, 1'b0, 1'b1);
    run_tx("hold2",   8'h06, 3'd2, 4'd0,  16'b110,       3, 1'b0, 1'b0);
`endif

    // Reset in the middle of the 4th bit of an 8-bit frame.
    bus.start   = 1'b1;
    bus.pattern = 8'hF0;
    bus.len     = 3'd7;
    bus.rep     = 4'd0;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("mid x", {31'd0, bus.x}, 32'd1);
      tick();
    end
    check("mid4 x",    {31'd0, bus.x},     32'd1);
    check("mid4 busy", {31'd0, bus.busy},  32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst x",     {31'd0, bus.x},     32'd0);
    check("arst x_vld", {31'd0, bus.x_vld}, 32'd0);
    check("arst busy",  {31'd0, bus.busy},  32'd0);
    check("arst done",  {31'd0, bus.done},  32'd0);
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("post x_vld", {31'd0, bus.x_vld}, 32'd0);
      check("post busy",  {31'd0, bus.busy},  32'd0);
      check("post done",  {31'd0, bus.done},  32'd0);
    end
    $display("tx reset_abort pat=f0 len=7 rep=0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
